// File: rtl/pipe_delay_reg_if.sv
// Bus bundle for pipe_delay_reg: the input item with its stall/flush
// controls, and the last-stage output with the occupancy status.
interface pipe_delay_reg_if #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 3
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [CNTW-1:0]  count;
  logic             empty;

  modport master (
    output in_data, in_valid, stall, flush,
    input  out_data, out_valid, count, empty
  );

  modport slave (
    input  in_data, in_valid, stall, flush,
    output out_data, out_valid, count, empty
  );
endinterface

// File: rtl/pipe_delay_reg.sv
// DEPTH-stage, WIDTH-bit pipeline register chain with per-stage valid bits,
// global stall/flush and occupancy count. Bubbles always carry zero data.
module pipe_delay_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input logic              clk,
  input logic              reset,
  pipe_delay_reg_if.slave  bus
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] v_r;
  logic [CNTW-1:0]  count_s;
  logic             empty_s;

  // Stage update: reset and flush both clear, stall holds, otherwise shift by one.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
        v_r[k]    <= 1'b0;
      end
    end else if (bus.stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= data_r[k];
        v_r[k]    <= v_r[k];
      end
    end else begin
      // Gating on in_valid keeps unknown data on idle cycles out of the chain.
      data_r[0] <= bus.in_valid ? bus.in_data : {WIDTH{1'b0}};
      v_r[0]    <= bus.in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_r[k] <= data_r[k-1];
        v_r[k]    <= v_r[k-1];
      end
    end
  end

  // Occupancy: population count of the stage valid bits.
  always_comb begin
    count_s = {CNTW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      count_s = count_s + CNTW'(v_r[k]);
    end
    empty_s = (count_s == {CNTW{1'b0}});
  end

  assign bus.out_data  = data_r[DEPTH-1];
  assign bus.out_valid = v_r[DEPTH-1];
  assign bus.count     = count_s;
  assign bus.empty     = empty_s;

endmodule

// File: tb/tb_pipe_delay_reg.sv
// Directed bench for pipe_delay_reg: a DEPTH=4/WIDTH=64 instance and a
// DEPTH=1/WIDTH=8 instance, with hand-computed expectations after each edge.
module tb_pipe_delay_reg;

  logic clk = 1'b0;
  logic reset4;
  logic reset1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_delay_reg_if #(.WIDTH(64), .CNTW(3)) b4 ();
  pipe_delay_reg_if #(.WIDTH(8),  .CNTW(1)) b1 ();

  pipe_delay_reg #(.WIDTH(64), .DEPTH(4), .CNTW(3)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (b4)
  );

  pipe_delay_reg #(.WIDTH(8), .DEPTH(1), .CNTW(1)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (b1)
  );

  logic [63:0] seq_d   [3] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
  int          seq_cnt [7] = '{1, 2, 3, 3, 2, 1, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic ev, input logic [63:0] ed, input int ec);
    chk({tag, "_valid"}, {63'd0, b4.out_valid}, {63'd0, ev});
    chk({tag, "_data"},  b4.out_data, ed);
    chk({tag, "_count"}, {61'd0, b4.count}, 64'(ec));
    chk({tag, "_empty"}, {63'd0, b4.empty}, {63'd0, (ec == 0)});
  endtask

  task automatic chk1(input string tag, input logic ev, input logic [7:0] ed);
    chk({tag, "_valid"}, {63'd0, b1.out_valid}, {63'd0, ev});
    chk({tag, "_data"},  {56'd0, b1.out_data}, {56'd0, ed});
    chk({tag, "_count"}, {63'd0, b1.count}, {63'd0, ev});
    chk({tag, "_empty"}, {63'd0, b1.empty}, {63'd0, ~ev});
  endtask

  task automatic drive4(input logic v, input logic [63:0] d, input logic s, input logic f);
    b4.in_valid = v;
    b4.in_data  = d;
    b4.stall    = s;
    b4.flush    = f;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic s, input logic f);
    b1.in_valid = v;
    b1.in_data  = d;
    b1.stall    = s;
    b1.flush    = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ev;
    logic [63:0] ed;
    int          idx;

    // Reset both instances, then idle.
    reset4 = 1'b1;
    reset1 = 1'b1;
    drive4(1'b0, 64'd0, 1'b0, 1'b0);
    drive1(1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    chk4("reset", 1'b0, 64'd0, 0);
    chk1("reset1", 1'b0, 8'd0);
    reset4 = 1'b0;
    reset1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk4("idle", 1'b0, 64'd0, 0);
    end

    // Three consecutive items, no stall: out after edge 4, counts 1,2,3,3,2,1,0.
    for (int e = 1; e <= 7; e++) begin
      if (e <= 3) drive4(1'b1, seq_d[e-1], 1'b0, 1'b0);
      else        drive4(1'b0, 64'd0, 1'b0, 1'b0);
      tick();
      ev = (e >= 4) && (e <= 6);
      ed = ev ? seq_d[e-4] : 64'd0;
      chk4("stream", ev, ed, seq_cnt[e-1]);
    end

    // One item then three stalled edges offering 0xDEAD...: item shows after edge 7.
    for (int e = 1; e <= 8; e++) begin
      if (e == 1)      drive4(1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0);
      else if (e <= 4) drive4(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
      else             drive4(1'b0, 64'd0, 1'b0, 1'b0);
      tick();
      ev = (e == 7);
      chk4("stall", ev, ev ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'd0, (e <= 7) ? 1 : 0);
    end

    // Fill with items 1..4, push a fifth into a full chain, then flush+stall+valid.
    for (int e = 1; e <= 5; e++) begin
      drive4(1'b1, 64'(e), 1'b0, 1'b0);
      tick();
    end
    chk4("full", 1'b1, 64'd2, 4);
    drive4(1'b1, 64'h9999_9999_9999_9999, 1'b1, 1'b1);
    tick();
    chk4("flush", 1'b0, 64'd0, 0);
    drive4(1'b0, 64'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk4("post_flush", 1'b0, 64'd0, 0);
    end

    // Alternating valid 0x5 / invalid 0xFFFF.
    for (int e = 1; e <= 12; e++) begin
      if (e <= 8) drive4((e % 2) == 1, ((e % 2) == 1) ? 64'h5 : 64'hFFFF, 1'b0, 1'b0);
      else        drive4(1'b0, 64'd0, 1'b0, 1'b0);
      tick();
      idx = e - 3;
      ev = (idx >= 1) && (idx <= 8) && ((idx % 2) == 1);
      chk("alt_valid", {63'd0, b4.out_valid}, {63'd0, ev});
      chk("alt_data", b4.out_data, ev ? 64'h5 : 64'd0);
      chk("alt_count_le2", {63'd0, (b4.count <= 3'd2)}, 64'd1);
    end

    // Unknown data on an idle cycle must travel as zero.
    drive4(1'b0, 64'hx, 1'b0, 1'b0);
    tick();
    drive4(1'b0, 64'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      chk4("xdata", 1'b0, 64'd0, 0);
      tick();
    end

    // DEPTH=1: push 0x7F, then reset with a valid input present.
    drive1(1'b1, 8'h7F, 1'b0, 1'b0);
    tick();
    chk1("d1_push", 1'b1, 8'h7F);
    reset1 = 1'b1;
    drive1(1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    chk1("d1_reset", 1'b0, 8'h00);
    reset1 = 1'b0;
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk1("d1_after", 1'b0, 8'h00);

    // DEPTH=1 stall hold and flush.
    drive1(1'b1, 8'h42, 1'b0, 1'b0);
    tick();
    drive1(1'b1, 8'h11, 1'b1, 1'b0);
    tick();
    tick();
    chk1("d1_stall", 1'b1, 8'h42);
    drive1(1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    chk1("d1_flush", 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
